// File: rtl/fpdiv_rr_scheduler.sv
// Round-robin front end that time-shares one fpdiv divider between NREQ requesters,
// sequencing the divider through RESET/DONE and guarding each operation with a watchdog.
module fpdiv_rr_scheduler #(
  parameter int NREQ      = 2,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [NREQ-1:0]     REQ_VALID,
  output logic [NREQ-1:0]     REQ_READY,
  input  logic [32*NREQ-1:0]  REQ_A,
  input  logic [32*NREQ-1:0]  REQ_B,
  output logic [NREQ-1:0]     RSP_VALID,
  input  logic [NREQ-1:0]     RSP_READY,
  output logic [31:0]         RSP_DATA,
  output logic [1:0]          RSP_EXC,
  output logic                RSP_TIMEOUT,
  output logic [31:0]         DIV_A,
  output logic [31:0]         DIV_B,
  output logic                DIV_RESET,
  input  logic [31:0]         DIV_RESULT,
  input  logic                DIV_DONE,
  input  logic [1:0]          DIV_EXC
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int unsigned NQ = NREQ;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_nx;
  logic [CW-1:0]   cnt;
  logic            found;
  logic            accept;
  logic            done_ok;
  logic            wd_expire;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      cand = PW'((32'(ptr) + i) % NQ);
      if (!found && REQ_VALID[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept    = (state == S_IDLE) && found;
  assign ptr_nx    = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
  // A DONE seen in the very first RUN cycle may be left over from the previous operation.
  assign done_ok   = (state == S_RUN) && (cnt != '0) && DIV_DONE;
  assign wd_expire = (state == S_RUN) && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    REQ_READY = '0;
    RSP_VALID = '0;
    DIV_RESET = 1'b1;
    case (state)
      S_IDLE: begin
        if (found) begin
          REQ_READY[grant] = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt == CW'(SETUP_CYC - 1)) state_nx = S_RUN;
      end
      S_RUN: begin
        DIV_RESET = 1'b0;
        if (done_ok || wd_expire) state_nx = S_RESP;
      end
      S_RESP: begin
        RSP_VALID[owner] = 1'b1;
        if (RSP_READY[owner]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= S_IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      RSP_DATA    <= '0;
      RSP_EXC     <= '0;
      RSP_TIMEOUT <= 1'b0;
      DIV_A       <= '0;
      DIV_B       <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state == S_LOAD || state == S_RUN) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        DIV_A <= REQ_A[32*grant +: 32];
        DIV_B <= REQ_B[32*grant +: 32];
        owner <= grant;
        ptr   <= ptr_nx;
      end
      // A real DONE wins over the watchdog when both land in the same cycle.
      if (done_ok) begin
        RSP_DATA    <= DIV_RESULT;
        RSP_EXC     <= DIV_EXC;
        RSP_TIMEOUT <= 1'b0;
      end else if (wd_expire) begin
        RSP_DATA    <= QNAN;
        RSP_EXC     <= '0;
        RSP_TIMEOUT <= 1'b1;
      end
    end
  end

endmodule
